dpram_access_arbiter: RTL and testbench

Arbitrates two requesters (port 0, port 1) onto the single register-mapped interface of the dual-port RAM peripheral and generates its multi-cycle access sequences. Each requester issues a simple word-level read or write with an 8-bit memory address. The arbiter turns it into the peripheral's register writes: data register at 0x0, address register at 0x4, command at 0x8, read data at 0x2. It sits between the bus-side masters and the RAM peripheral, and is the only block that drives the peripheral.

---
 rtl/dpram_access_arbiter.sv | 152 +++++++++++++++
 tb/tb_dpram_access_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_access_arbiter.sv
// dpram_access_arbiter
//   Two-port round-robin arbiter in front of the dual-port RAM peripheral.
//   Each granted word read/write is expanded into the peripheral's register
//   sequence: data (0x0), address (0x4), command (0x8), read strobe (0x2).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   req0/1, we0/1            request (held until ack) and write enable
//   maddr0/1, wdata0/1       RAM word address and write data
//   ack0/1                   one-cycle completion pulse
//   rdata0/1                 read result, valid at ack, held until next read
//   busy                     high whenever the sequencer is not idle
//   ram_cs/wr/rd, ram_addr   peripheral strobes and register select
//   ram_dp_mem_addr          memory address presented to the peripheral
//   ram_dat_in / ram_dat_out data to / from the peripheral
module dpram_access_arbiter #(
  parameter int unsigned READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [7:0]  maddr0,
  input  logic [7:0]  maddr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic        busy,
  output logic        ram_cs,
  output logic        ram_wr,
  output logic        ram_rd,
  output logic [3:0]  ram_addr,
  output logic [7:0]  ram_dp_mem_addr,
  output logic [15:0] ram_dat_in,
  input  logic [15:0] ram_dat_out
);

  typedef enum logic [3:0] {
    IDLE, W_DATA, W_ADDR, W_CMD, R_ADDR, R_CMD, R_STRB, R_WAIT, DONE
  } state_t;

  state_t      state, state_nxt;
  logic        port_q;      // port currently being served
  logic        last_q;      // port granted most recently (round-robin pointer)
  logic [7:0]  maddr_q;
  logic [15:0] wdata_q;
  logic [7:0]  maddr_hold;
  logic [15:0] wdata_hold;
  logic [2:0]  wait_cnt;
  logic        grant_any;
  logic        grant_port;
  logic        rd_last;

  // On a collision the port not granted last wins.
  always_comb begin
    grant_any = req0 | req1;
    if (req0 && req1) grant_port = ~last_q;
    else              grant_port = req1 & ~req0;
  end

  // Last cycle of the R_STRB/R_WAIT window: read data is valid here.
  always_comb begin
    rd_last = 1'b0;
    if (state == R_STRB && READ_LAT == 1) rd_last = 1'b1;
    if (state == R_WAIT && wait_cnt == 3'(READ_LAT - 2)) rd_last = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_any) state_nxt = (grant_port ? we1 : we0) ? W_DATA : R_ADDR;
      W_DATA:  state_nxt = W_ADDR;
      W_ADDR:  state_nxt = W_CMD;
      W_CMD:   state_nxt = DONE;
      R_ADDR:  state_nxt = R_CMD;
      R_CMD:   state_nxt = R_STRB;
      R_STRB:  state_nxt = rd_last ? DONE : R_WAIT;
      R_WAIT:  state_nxt = rd_last ? DONE : R_WAIT;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Moore decode of the peripheral interface. Address/data outputs show the
  // latched fields in their own states and the last driven value elsewhere.
  always_comb begin
    ram_cs   = 1'b0;
    ram_wr   = 1'b0;
    ram_rd   = 1'b0;
    ram_addr = 4'h0;
    case (state)
      W_DATA: begin
        ram_cs = 1'b1; ram_wr = 1'b1; ram_addr = 4'h0;
      end
      W_ADDR, R_ADDR: begin
        ram_cs = 1'b1; ram_wr = 1'b1; ram_addr = 4'h4;
      end
      W_CMD, R_CMD: begin
        ram_cs = 1'b1; ram_wr = 1'b1; ram_addr = 4'h8;
      end
      R_STRB, R_WAIT: begin
        ram_cs = 1'b1; ram_rd = 1'b1; ram_addr = 4'h2;
      end
      default: ;
    endcase
    ram_dp_mem_addr = (state == W_ADDR || state == R_ADDR) ? maddr_q : maddr_hold;
    ram_dat_in      = (state == W_DATA) ? wdata_q : wdata_hold;
    ack0            = (state == DONE) && !port_q;
    ack1            = (state == DONE) &&  port_q;
    busy            = (state != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_q     <= 1'b0;
      last_q     <= 1'b1;
      maddr_q    <= '0;
      wdata_q    <= '0;
      maddr_hold <= '0;
      wdata_hold <= '0;
      wait_cnt   <= '0;
      rdata0     <= '0;
      rdata1     <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        port_q  <= grant_port;
        maddr_q <= grant_port ? maddr1 : maddr0;
        wdata_q <= grant_port ? wdata1 : wdata0;
      end
      if (state == W_ADDR || state == R_ADDR) maddr_hold <= maddr_q;
      if (state == W_DATA) wdata_hold <= wdata_q;
      if (state == R_STRB)      wait_cnt <= '0;
      else if (state == R_WAIT) wait_cnt <= wait_cnt + 3'd1;
      if (rd_last) begin
        if (port_q) rdata1 <= ram_dat_out;
        else        rdata0 <= ram_dat_out;
      end
      if (state == DONE) last_q <= port_q;
    end
  end

endmodule

// File: tb/tb_dpram_access_arbiter.sv
module tb_dpram_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Index 0: READ_LAT=3 instance, index 1: READ_LAT=1 instance.
  logic [1:0]       req0, req1, we0, we1, ack0, ack1, busy, cs, wr, rd;
  logic [1:0][7:0]  maddr0, maddr1, ma;
  logic [1:0][15:0] wdata0, wdata1, rdata0, rdata1, di, dout;
  logic [1:0][3:0]  ra;

  // Peripheral stand-in state.
  logic [15:0]      mem [2][256];
  logic [1:0][15:0] dreg;
  logic [1:0][7:0]  areg;
  logic [1:0]       pend;
  logic [1:0][2:0]  rcnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dpram_access_arbiter #(.READ_LAT(3)) u_lat3 (
    .clk(clk), .rst(rst),
    .req0(req0[0]), .req1(req1[0]), .we0(we0[0]), .we1(we1[0]),
    .maddr0(maddr0[0]), .maddr1(maddr1[0]), .wdata0(wdata0[0]), .wdata1(wdata1[0]),
    .ack0(ack0[0]), .ack1(ack1[0]), .rdata0(rdata0[0]), .rdata1(rdata1[0]),
    .busy(busy[0]), .ram_cs(cs[0]), .ram_wr(wr[0]), .ram_rd(rd[0]),
    .ram_addr(ra[0]), .ram_dp_mem_addr(ma[0]), .ram_dat_in(di[0]),
    .ram_dat_out(dout[0])
  );

  dpram_access_arbiter #(.READ_LAT(1)) u_lat1 (
    .clk(clk), .rst(rst),
    .req0(req0[1]), .req1(req1[1]), .we0(we0[1]), .we1(we1[1]),
    .maddr0(maddr0[1]), .maddr1(maddr1[1]), .wdata0(wdata0[1]), .wdata1(wdata1[1]),
    .ack0(ack0[1]), .ack1(ack1[1]), .rdata0(rdata0[1]), .rdata1(rdata1[1]),
    .busy(busy[1]), .ram_cs(cs[1]), .ram_wr(wr[1]), .ram_rd(rd[1]),
    .ram_addr(ra[1]), .ram_dp_mem_addr(ma[1]), .ram_dat_in(di[1]),
    .ram_dat_out(dout[1])
  );

  function automatic logic [2:0] lat_m1(input int i);
    return (i == 0) ? 3'd2 : 3'd0;
  endfunction

  // Peripheral: 0x0 loads data, 0x4 loads address, 0x8 commits a pending
  // write. Read data appears only in the READ_LAT-th strobe cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      rcnt <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (cs[i] && wr[i]) begin
          case (ra[i])
            4'h0: begin dreg[i] <= di[i]; pend[i] <= 1'b1; end
            4'h4: areg[i] <= ma[i];
            4'h8: begin
              if (pend[i]) mem[i][areg[i]] <= dreg[i];
              pend[i] <= 1'b0;
            end
            default: ;
          endcase
        end
        rcnt[i] <= (cs[i] && rd[i]) ? rcnt[i] + 3'd1 : 3'd0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dout[i] = 16'hDEAD;
      if (cs[i] && rd[i] && ra[i] == 4'h2 && rcnt[i] == lat_m1(i))
        dout[i] = mem[i][areg[i]];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request from IDLE, hold it until ack (bounded), check the ack
  // arrives in cycle exp_cyc on its own port only, then drop it.
  task automatic txn(input int i, input int p, input logic w, input logic [7:0] a,
                     input logic [15:0] d, input int exp_cyc, output logic [15:0] rd_at_ack);
    int   cyc = 0;
    logic got = 1'b0;
    if (p == 0) begin req0[i] = 1'b1; we0[i] = w; maddr0[i] = a; wdata0[i] = d; end
    else        begin req1[i] = 1'b1; we1[i] = w; maddr1[i] = a; wdata1[i] = d; end
    while (!got && cyc < 20) begin
      step();
      cyc++;
      if ((p == 0) ? ack0[i] : ack1[i]) got = 1'b1;
    end
    rd_at_ack = (p == 0) ? rdata0[i] : rdata1[i];
    chk("txn_ack_cycle", got ? 32'(cyc) : 32'hFFFF_FFFF, 32'(exp_cyc));
    chk("txn_other_ack", (p == 0) ? ack1[i] : ack0[i], 0);
    if (p == 0) req0[i] = 1'b0;
    else        req1[i] = 1'b0;
    step();
  endtask

  initial begin
    logic [15:0] r;
    int          n, cs_hi, cs_at_ack, both;
    int          ack_at [3];
    logic [3:0]  ord;

    req0 = '0; req1 = '0; we0 = '0; we1 = '0;
    maddr0 = '0; maddr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    #2;
    for (int i = 0; i < 2; i++) begin
      chk("rst_ctl", {ack0[i], ack1[i], busy[i], cs[i], wr[i], rd[i], ra[i]}, 0);
      chk("rst_rdata", {rdata0[i], rdata1[i]}, 0);
      chk("rst_ram_bus", {ma[i], di[i]}, 0);
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single write, port 0, cycle by cycle
    req0[0] = 1'b1; we0[0] = 1'b1; maddr0[0] = 8'h80; wdata0[0] = 16'h000B;
    chk("wr_c0_busy", busy[0], 0);
    step();
    chk("wr_c1_strb", {cs[0], wr[0], rd[0], ra[0]}, {3'b110, 4'h0});
    chk("wr_c1_data", di[0], 16'h000B);
    chk("wr_c1_busy", busy[0], 1);
    step();
    chk("wr_c2_strb", {cs[0], wr[0], rd[0], ra[0]}, {3'b110, 4'h4});
    chk("wr_c2_maddr", ma[0], 8'h80);
    step();
    chk("wr_c3_strb", {cs[0], wr[0], rd[0], ra[0]}, {3'b110, 4'h8});
    chk("wr_c3_ack", ack0[0], 0);
    step();
    chk("wr_c4_ack", {ack0[0], ack1[0], busy[0]}, 3'b101);
    chk("wr_c4_strb", {cs[0], wr[0], rd[0]}, 0);
    chk("wr_c4_hold", {ma[0], di[0]}, {8'h80, 16'h000B});
    req0[0] = 1'b0;
    step();
    chk("wr_c5_idle", {ack0[0], busy[0]}, 0);

    // Write then read back on port 1, READ_LAT=3 and READ_LAT=1
    txn(0, 1, 1'b1, 8'h55, 16'h00FF, 4, r);
    txn(0, 1, 1'b0, 8'h55, 16'h0000, 6, r);
    chk("rb_lat3_rdata", r, 16'h00FF);
    txn(1, 1, 1'b1, 8'h55, 16'h00FF, 4, r);
    txn(1, 1, 1'b0, 8'h55, 16'h0000, 4, r);
    chk("rb_lat1_rdata", r, 16'h00FF);

    // rdata retention across another port's write
    txn(0, 0, 1'b1, 8'h12, 16'hBEEF, 4, r);
    txn(0, 0, 1'b0, 8'h12, 16'h0000, 6, r);
    chk("ret_read", r, 16'hBEEF);
    txn(0, 1, 1'b1, 8'h34, 16'h1234, 4, r);
    chk("ret_rdata0", rdata0[0], 16'hBEEF);
    chk("ret_rdata1", rdata1[0], 16'h00FF);

    // Held request: three back-to-back writes on port 0
    req0[0] = 1'b1; we0[0] = 1'b1; maddr0[0] = 8'h20; wdata0[0] = 16'h1111;
    n = 0; cs_hi = 0; cs_at_ack = 0;
    ack_at = '{0, 0, 0};
    for (int cyc = 1; cyc <= 14; cyc++) begin
      step();
      if (cs[0]) cs_hi++;
      if (ack0[0]) begin
        if (n < 3) ack_at[n] = cyc;
        n++;
        if (cs[0]) cs_at_ack++;
      end
      if (cyc == 14) req0[0] = 1'b0;
    end
    step();
    chk("held_ack_count", n, 3);
    chk("held_ack_cycles", {ack_at[0][7:0], ack_at[1][7:0], ack_at[2][7:0]}, {8'd4, 8'd9, 8'd14});
    chk("held_cs_cycles", cs_hi, 9);
    chk("held_cs_gap", cs_at_ack, 0);

    // Reset during R_CMD of a port-0 read
    req0[0] = 1'b1; we0[0] = 1'b0; maddr0[0] = 8'h12;
    step();
    step();
    chk("rmr_in_cmd", {cs[0], wr[0], rd[0], ra[0]}, {3'b110, 4'h8});
    #1 rst = 1'b1;
    #1;
    chk("rmr_strobes", {cs[0], wr[0], rd[0], busy[0], ack0[0]}, 0);
    chk("rmr_rdata0", rdata0[0], 0);
    req0[0] = 1'b0;
    step();
    rst = 1'b0;
    n = 0;
    repeat (6) begin
      step();
      if (ack0[0] || ack1[0]) n++;
    end
    chk("rmr_no_ack", n, 0);

    // Collision after reset: port 0 first, then strict alternation
    req0[0] = 1'b1; we0[0] = 1'b1; maddr0[0] = 8'h40; wdata0[0] = 16'hA0A0;
    req1[0] = 1'b1; we1[0] = 1'b1; maddr1[0] = 8'h41; wdata1[0] = 16'hB1B1;
    n = 0; both = 0; ord = '0;
    for (int cyc = 1; cyc <= 19; cyc++) begin
      step();
      if (ack0[0] && ack1[0]) both++;
      else if (ack0[0]) begin ord = {ord[2:0], 1'b0}; n++; end
      else if (ack1[0]) begin ord = {ord[2:0], 1'b1}; n++; end
      if (cyc == 19) begin req0[0] = 1'b0; req1[0] = 1'b0; end
    end
    step();
    chk("col_ack_count", n, 4);
    chk("col_order", ord, 4'b0101);
    chk("col_both_acks", both, 0);
    chk("col_idle", busy[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
